// File: rtl/pic_pkg.sv
// Shared types and command codes for the pic_ctrl_core interrupt controller.
// Holds the init and INTA state encodings, the OCW2 commands and the read-select codes.
package pic_pkg;

    typedef enum logic [2:0] {
        WAIT_ICW1,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } init_state_e;

    typedef enum logic [1:0] {
        INTA_IDLE,
        INTA_ACK1,
        INTA_ACK2
    } inta_state_e;

    localparam logic [2:0] OCW2_CLR_RAEOI = 3'b000;
    localparam logic [2:0] OCW2_NSEOI     = 3'b001;
    localparam logic [2:0] OCW2_SEOI      = 3'b011;
    localparam logic [2:0] OCW2_SET_RAEOI = 3'b100;
    localparam logic [2:0] OCW2_ROT_NSEOI = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO  = 3'b110;
    localparam logic [2:0] OCW2_ROT_SEOI  = 3'b111;

    localparam logic RSEL_IRR = 1'b0;
    localparam logic RSEL_ISR = 1'b1;

endpackage

// File: rtl/pic_prio_resolver.sv
// Combinational rotating priority encoder: the channel just after lowest_prio_i
// has rank 0 (highest); returns the highest-ranked set request.
module pic_prio_resolver #(
    parameter  int NUM_IRQ = 8,
    localparam int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req_i,
    input  logic [ID_W-1:0]    lowest_prio_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    id_o
);

    logic [NUM_IRQ-1:0] rot_req;
    logic [ID_W-1:0]    rank;

    // rot_req[r] is the request holding rank r; NUM_IRQ is a power of two so wrap is free
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_rot
            logic [ID_W-1:0] src;
            assign src         = lowest_prio_i + ID_W'(gi + 1);
            assign rot_req[gi] = req_i[src];
        end
    endgenerate

    always_comb begin
        rank = '0;
        for (int r = NUM_IRQ - 1; r >= 0; r--) begin
            if (rot_req[r]) begin
                rank = ID_W'(r);
            end
        end
    end

    assign valid_o = |req_i;
    assign id_o    = lowest_prio_i + rank + ID_W'(1);

endmodule

// File: rtl/pic_ctrl_core.sv
// 8259-style interrupt controller core: ICW/OCW programming, IRR/IMR/ISR, INTA vectoring.
// Optional special-mask mode is compiled in when PIC_SPECIAL_MASK_EN is defined.
module pic_ctrl_core
    import pic_pkg::*;
#(
    parameter  int NUM_IRQ = 8,
    localparam int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic               a0,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic               rdata_vld,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               inta_n,
    output logic               int_o,
    output logic               init_done
);

    init_state_e        init_q, init_d;
    inta_state_e        inta_q, inta_d;
    logic               ic4_q, ic4_d, sngl_q, sngl_d, ltim_q, ltim_d;
    logic               aeoi_q, aeoi_d, raeoi_q, raeoi_d, rsel_q, rsel_d;
    logic [4:0]         base_q, base_d;
    logic [NUM_IRQ-1:0] irr_q, irr_d, imr_q, imr_d, isr_q, isr_d, irq_prev_q;
    logic [ID_W-1:0]    lowest_q, lowest_d, ack_id_q, ack_id_d;
    logic               ack_spur_q, ack_spur_d;
    logic               inta_prev_q, int_q, int_d, vld_q, vld_d;
    logic [7:0]         rdata_q, rdata_d;

    logic [NUM_IRQ-1:0] isr_block;
    logic               req_vld, isr_vld, win, icw1, inta_fall, inta_rise;
    logic [ID_W-1:0]    req_id, isr_id, req_rank, isr_rank, sel_id;

`ifdef PIC_SPECIAL_MASK_EN
    logic smm_q, smm_d;
    assign isr_block = isr_q & ~(smm_q ? imr_q : '0);
`else
    assign isr_block = isr_q;
`endif

    pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_req_res (
        .req_i(irr_q & ~imr_q), .lowest_prio_i(lowest_q), .valid_o(req_vld), .id_o(req_id)
    );
    pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_isr_res (
        .req_i(isr_block), .lowest_prio_i(lowest_q), .valid_o(isr_vld), .id_o(isr_id)
    );

    assign req_rank  = req_id - lowest_q - ID_W'(1);
    assign isr_rank  = isr_id - lowest_q - ID_W'(1);
    assign win       = req_vld && (!isr_vld || (req_rank < isr_rank));
    assign icw1      = wr_en && !a0 && wdata[4];
    assign inta_fall = inta_prev_q && !inta_n;
    assign inta_rise = !inta_prev_q && inta_n;
    assign sel_id    = wdata[ID_W-1:0];

    always_comb begin
        init_d     = init_q;
        inta_d     = inta_q;
        ic4_d      = ic4_q;
        sngl_d     = sngl_q;
        ltim_d     = ltim_q;
        aeoi_d     = aeoi_q;
        raeoi_d    = raeoi_q;
        rsel_d     = rsel_q;
        base_d     = base_q;
        imr_d      = imr_q;
        isr_d      = isr_q;
        lowest_d   = lowest_q;
        ack_id_d   = ack_id_q;
        ack_spur_d = ack_spur_q;
        irr_d      = ltim_q ? irq_i : (irr_q | (irq_i & ~irq_prev_q));
        int_d      = (init_q == READY) && win;
        vld_d      = 1'b0;
        rdata_d    = rdata_q;
`ifdef PIC_SPECIAL_MASK_EN
        smm_d      = smm_q;
`endif
        if (rd_en) begin
            vld_d   = 1'b1;
            rdata_d = a0 ? 8'(imr_q) : ((rsel_q == RSEL_ISR) ? 8'(isr_q) : 8'(irr_q));
        end
        if (icw1) begin
            ic4_d    = wdata[0];
            sngl_d   = wdata[1];
            ltim_d   = wdata[3];
            imr_d    = '0;
            isr_d    = '0;
            lowest_d = ID_W'(NUM_IRQ - 1);
            inta_d   = INTA_IDLE;
            init_d   = WAIT_ICW2;
            int_d    = 1'b0;
        end else begin
            if (wr_en) begin
                case (init_q)
                    WAIT_ICW2: if (a0) begin
                        base_d = wdata[7:3];
                        init_d = !sngl_q ? WAIT_ICW3 : (ic4_q ? WAIT_ICW4 : READY);
                    end
                    // Cascade is not modelled, so ICW3 is accepted and discarded.
                    WAIT_ICW3: if (a0) init_d = ic4_q ? WAIT_ICW4 : READY;
                    WAIT_ICW4: if (a0) begin
                        aeoi_d = wdata[1];
                        init_d = READY;
                    end
                    READY: begin
                        if (a0) begin
                            imr_d = wdata[NUM_IRQ-1:0];
                        end else if (wdata[4:3] == 2'b00) begin
                            case (wdata[7:5])
                                OCW2_NSEOI:     if (isr_vld) isr_d[isr_id] = 1'b0;
                                OCW2_SEOI:      isr_d[sel_id] = 1'b0;
                                OCW2_ROT_NSEOI: if (isr_vld) begin
                                    isr_d[isr_id] = 1'b0;
                                    lowest_d      = isr_id;
                                end
                                OCW2_ROT_SEOI:  if (|isr_q) begin
                                    isr_d[sel_id] = 1'b0;
                                    lowest_d      = sel_id;
                                end
                                OCW2_SET_PRIO:  lowest_d = sel_id;
                                OCW2_SET_RAEOI: raeoi_d = 1'b1;
                                OCW2_CLR_RAEOI: raeoi_d = 1'b0;
                                default: ;
                            endcase
                        end else if (wdata[4:3] == 2'b01) begin
                            if (wdata[1]) rsel_d = wdata[0];
`ifdef PIC_SPECIAL_MASK_EN
                            if (wdata[6:5] == 2'b11) smm_d = 1'b1;
                            if (wdata[6:5] == 2'b10) smm_d = 1'b0;
`endif
                        end
                    end
                    default: ;
                endcase
            end
            // Evaluated after the OCW writes so an acknowledge wins over an EOI to the same bit.
            if (init_q == READY) begin
                case (inta_q)
                    INTA_IDLE: if (inta_fall) begin
                        inta_d = INTA_ACK1;
                        int_d  = 1'b0;
                        if (win) begin
                            ack_id_d      = req_id;
                            ack_spur_d    = 1'b0;
                            isr_d[req_id] = 1'b1;
                            irr_d[req_id] = 1'b0;
                        end else begin
                            ack_id_d   = ID_W'(NUM_IRQ - 1);
                            ack_spur_d = 1'b1;
                        end
                    end
                    INTA_ACK1: if (inta_fall) begin
                        rdata_d = {base_q, 3'(ack_id_q)};
                        vld_d   = 1'b1;
                        inta_d  = INTA_ACK2;
                    end
                    INTA_ACK2: if (inta_rise) begin
                        if (aeoi_q && !ack_spur_q) begin
                            isr_d[ack_id_q] = 1'b0;
                            if (raeoi_q) lowest_d = ack_id_q;
                        end
                        inta_d = INTA_IDLE;
                    end
                    default: inta_d = INTA_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q      <= WAIT_ICW1;
            inta_q      <= INTA_IDLE;
            ic4_q       <= 1'b0;
            sngl_q      <= 1'b0;
            ltim_q      <= 1'b0;
            aeoi_q      <= 1'b0;
            raeoi_q     <= 1'b0;
            rsel_q      <= RSEL_IRR;
            base_q      <= '0;
            irr_q       <= '0;
            imr_q       <= '0;
            isr_q       <= '0;
            irq_prev_q  <= '0;
            lowest_q    <= ID_W'(NUM_IRQ - 1);
            ack_id_q    <= '0;
            ack_spur_q  <= 1'b0;
            inta_prev_q <= 1'b1;
            int_q       <= 1'b0;
            vld_q       <= 1'b0;
            rdata_q     <= '0;
`ifdef PIC_SPECIAL_MASK_EN
            smm_q       <= 1'b0;
`endif
        end else begin
            init_q      <= init_d;
            inta_q      <= inta_d;
            ic4_q       <= ic4_d;
            sngl_q      <= sngl_d;
            ltim_q      <= ltim_d;
            aeoi_q      <= aeoi_d;
            raeoi_q     <= raeoi_d;
            rsel_q      <= rsel_d;
            base_q      <= base_d;
            irr_q       <= irr_d;
            imr_q       <= imr_d;
            isr_q       <= isr_d;
            irq_prev_q  <= irq_i;
            lowest_q    <= lowest_d;
            ack_id_q    <= ack_id_d;
            ack_spur_q  <= ack_spur_d;
            inta_prev_q <= inta_n;
            int_q       <= int_d;
            vld_q       <= vld_d;
            rdata_q     <= rdata_d;
`ifdef PIC_SPECIAL_MASK_EN
            smm_q       <= smm_d;
`endif
        end
    end

    assign rdata     = rdata_q;
    assign rdata_vld = vld_q;
    assign int_o     = int_q;
    assign init_done = (init_q == READY);

endmodule

// File: tb/tb_pic_ctrl_core.sv
// Directed bench for pic_ctrl_core: stimulus pushes expected rdata into a queue,
// a negedge monitor pops and compares on every rdata_vld.
module tb_pic_ctrl_core;

    localparam int NUM_IRQ = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               wr_en = 1'b0;
    logic               rd_en = 1'b0;
    logic               a0 = 1'b0;
    logic [7:0]         wdata = 8'h00;
    logic [7:0]         rdata;
    logic               rdata_vld;
    logic [NUM_IRQ-1:0] irq_i = '0;
    logic               inta_n = 1'b1;
    logic               int_o;
    logic               init_done;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    pic_ctrl_core #(.NUM_IRQ(NUM_IRQ)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .a0(a0),
        .wdata(wdata), .rdata(rdata), .rdata_vld(rdata_vld), .irq_i(irq_i),
        .inta_n(inta_n), .int_o(int_o), .init_done(init_done)
    );

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h expected=%02h", name, got, exp);
        end else begin
            $display("ok   %s = %02h", name, got);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_int(input string name, input logic exp);
        tick_n(3);
        check(name, {7'b0, int_o}, {7'b0, exp});
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        a0 = a; wdata = d; wr_en = 1'b1;
        tick_n(1);
        wr_en = 1'b0;
        tick_n(1);
    endtask

    task automatic rd(input logic a, input logic [7:0] exp);
        exp_q.push_back(exp);
        a0 = a; rd_en = 1'b1;
        tick_n(1);
        rd_en = 1'b0;
        tick_n(2);
    endtask

    task automatic inta_pulse();
        inta_n = 1'b0;
        tick_n(2);
        inta_n = 1'b1;
        tick_n(2);
    endtask

    task automatic ack_pair(input logic [7:0] vec);
        inta_pulse();
        exp_q.push_back(vec);
        inta_pulse();
    endtask

    task automatic init_pic(input logic [7:0] icw4);
        wr(1'b0, 8'h13);
        wr(1'b1, 8'h40);
        wr(1'b1, icw4);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && rdata_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdata_vld got=%02h expected=none", rdata);
            end else begin
                check("rdata", rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        tick_n(3);
        check("rst_rdata", rdata, 8'h00);
        check("rst_vld", {7'b0, rdata_vld}, 8'h00);
        check("rst_int", {7'b0, int_o}, 8'h00);
        check("rst_init_done", {7'b0, init_done}, 8'h00);
        rst_n = 1'b1;
        tick_n(2);

        // Basic edge-triggered request and vectoring
        init_pic(8'h01);
        check("init_done", {7'b0, init_done}, 8'h01);
        irq_i[3] = 1'b1;
        tick_n(2);
        irq_i[3] = 1'b0;
        check_int("t1_int_high", 1'b1);
        rd(1'b0, 8'h08);
        inta_pulse();
        check_int("t1_int_dropped", 1'b0);
        exp_q.push_back(8'h43);
        inta_pulse();
        wr(1'b0, 8'h0B);
        rd(1'b0, 8'h08);
        wr(1'b0, 8'h0A);
        rd(1'b0, 8'h00);

        // Fully nested blocking and non-specific EOI
        irq_i[5] = 1'b1;
        check_int("t2_irq5_blocked", 1'b0);
        irq_i[1] = 1'b1;
        check_int("t2_irq1_int", 1'b1);
        ack_pair(8'h41);
        wr(1'b0, 8'h0B);
        rd(1'b0, 8'h0A);
        wr(1'b0, 8'h20);
        rd(1'b0, 8'h08);
        check_int("t2_still_blocked", 1'b0);
        wr(1'b0, 8'h20);
        check_int("t2_irq5_released", 1'b1);
        ack_pair(8'h45);
        irq_i = '0;
        wr(1'b0, 8'h65);
        rd(1'b0, 8'h00);

        // Rotated priority: lowest = 4, so 6 outranks 2
        wr(1'b0, 8'hC4);
        irq_i = 8'h44;
        check_int("t3_int", 1'b1);
        ack_pair(8'h46);
        irq_i = '0;
        check_int("t3_irq2_blocked", 1'b0);
        wr(1'b0, 8'h20);
        check_int("t3_irq2_released", 1'b1);
        ack_pair(8'h42);
        wr(1'b0, 8'h20);
        wr(1'b0, 8'hC7);

        // Fully masked: spurious vector, ISR untouched
        wr(1'b1, 8'hFF);
        irq_i[0] = 1'b1;
        check_int("t4_masked", 1'b0);
        rd(1'b1, 8'hFF);
        ack_pair(8'h47);
        wr(1'b0, 8'h0B);
        rd(1'b0, 8'h00);
        wr(1'b0, 8'h0A);
        rd(1'b0, 8'h01);
        wr(1'b1, 8'h00);
        check_int("t4_unmasked", 1'b1);
        ack_pair(8'h40);
        irq_i = '0;
        wr(1'b0, 8'h20);

        // ICW1 between the two INTA pulses aborts the sequence
        wr(1'b0, 8'h0B);
        irq_i[4] = 1'b1;
        check_int("t5_int", 1'b1);
        inta_pulse();
        irq_i = '0;
        wr(1'b0, 8'h13);
        inta_pulse();
        check("t5_init_done_low", {7'b0, init_done}, 8'h00);
        rd(1'b0, 8'h00);
        rd(1'b1, 8'h00);
        wr(1'b1, 8'h40);
        wr(1'b1, 8'h01);
        check("t5_back_to_ready", {7'b0, init_done}, 8'h01);

        // Automatic EOI on the trailing INTA edge
        init_pic(8'h03);
        irq_i[2] = 1'b1;
        tick_n(2);
        irq_i[2] = 1'b0;
        check_int("t6_int", 1'b1);
        ack_pair(8'h42);
        wr(1'b0, 8'h0B);
        rd(1'b0, 8'h00);

        // Special-mask mode (only effective when compiled in)
        init_pic(8'h01);
        irq_i[3] = 1'b1;
        tick_n(2);
        irq_i[3] = 1'b0;
        check_int("t7_int", 1'b1);
        ack_pair(8'h43);
        wr(1'b1, 8'h08);
        wr(1'b0, 8'h68);
        irq_i[5] = 1'b1;
`ifdef PIC_SPECIAL_MASK_EN
        check_int("t7_smm_int", 1'b1);
`else
        check_int("t7_no_smm_blocked", 1'b0);
`endif
        irq_i = '0;

        tick_n(5);
        check("pending_responses", 8'(exp_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
